// File: rtl/control_posicion.sv
// control_posicion
//   Turns the four level-sensitive movement flags from the PS/2 decoder into a
//   bounded (X,Y) sprite position. The flags are resynchronised into Clk. A key
//   press gives one immediate step, then typematic auto-repeat while it is held.
//   The position saturates at the screen edges.
//
// Ports
//   Clk      in   system/pixel clock, rising edge
//   Reset    in   asynchronous, active-high
//   mIzq     in   left flag  (asynchronous to Clk)
//   mDer     in   right flag (asynchronous to Clk)
//   mArriba  in   up flag    (asynchronous to Clk)
//   mAbajo   in   down flag  (asynchronous to Clk)
//   PosX     out  [9:0] current X, registered
//   PosY     out  [8:0] current Y, registered
//   Moved    out  one-cycle pulse in the first cycle a changed position is shown
module control_posicion #(
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int STEP         = 8,
  parameter int DELAY_TICKS  = 12500000,
  parameter int REPEAT_TICKS = 2500000,
  parameter int CW           = 24
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       mIzq,
  input  logic       mDer,
  input  logic       mArriba,
  input  logic       mAbajo,
  output logic [9:0] PosX,
  output logic [8:0] PosY,
  output logic       Moved
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_WAIT_FIRST,
    S_WAIT_REPEAT
  } state_t;

  // Saturating horizontal step; r/l already exclude the cancelled case.
  function automatic logic [9:0] sat_step_x(input logic [9:0] x, input logic l, input logic r);
    int xi;
    xi = int'(x);
    if (r)      xi = (xi > X_MAX - STEP) ? X_MAX : xi + STEP;
    else if (l) xi = (xi < STEP) ? 0 : xi - STEP;
    return 10'(xi);
  endfunction

  // Saturating vertical step; up decreases Y.
  function automatic logic [8:0] sat_step_y(input logic [8:0] y, input logic u, input logic d);
    int yi;
    yi = int'(y);
    if (d)      yi = (yi > Y_MAX - STEP) ? Y_MAX : yi + STEP;
    else if (u) yi = (yi < STEP) ? 0 : yi - STEP;
    return 9'(yi);
  endfunction

  // Stage p0/p1: two-flop synchronizer, bit order {Izq, Der, Arriba, Abajo}
  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {mIzq, mDer, mArriba, mAbajo};
      sync_q <= meta_q;
    end
  end

  logic s_i, s_d, s_a, s_b;
  logic go_left, go_right, go_up, go_down, active;

  assign s_i = sync_q[3];
  assign s_d = sync_q[2];
  assign s_a = sync_q[1];
  assign s_b = sync_q[0];

  // Opposing keys cancel on their own axis only.
  assign go_right = s_d & ~s_i;
  assign go_left  = s_i & ~s_d;
  assign go_up    = s_a & ~s_b;
  assign go_down  = s_b & ~s_a;
  assign active   = go_right | go_left | go_up | go_down;

  // Stage p2: FSM, timer and position registers
  state_t        state_q;
  logic          first_q;
  logic [CW-1:0] timer_q;
  logic [9:0]    posx_q, posx_d;
  logic [8:0]    posy_q, posy_d;
  logic          moved_q;

  assign posx_d = sat_step_x(posx_q, go_left, go_right);
  assign posy_d = sat_step_y(posy_q, go_up, go_down);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
      timer_q <= '0;
      posx_q  <= 10'(X_INIT);
      posy_q  <= 9'(Y_INIT);
      moved_q <= 1'b0;
    end else begin
      moved_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (active) begin
            state_q <= S_STEP;
            first_q <= 1'b1;
          end
        end
        S_STEP: begin
          if (active) begin
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            // A step fully absorbed by clamping keeps its timing but no pulse.
            moved_q <= (posx_d != posx_q) || (posy_d != posy_q);
            if (first_q) begin
              state_q <= S_WAIT_FIRST;
              timer_q <= CW'(DELAY_TICKS - 1);
            end else begin
              state_q <= S_WAIT_REPEAT;
              timer_q <= CW'(REPEAT_TICKS - 1);
            end
          end else begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end
        end
        S_WAIT_FIRST, S_WAIT_REPEAT: begin
          if (!active) begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end else if (timer_q == '0) begin
            state_q <= S_STEP;
            first_q <= 1'b0;
          end else begin
            timer_q <= timer_q - CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign PosX  = posx_q;
  assign PosY  = posy_q;
  assign Moved = moved_q;

endmodule

// File: tb/tb_control_posicion.sv
module tb_control_posicion;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       mIzq, mDer, mArriba, mAbajo;
  logic [9:0] PosX;
  logic [8:0] PosY;
  logic       Moved;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses;

  control_posicion #(
    .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240), .STEP(8),
    .DELAY_TICKS(10), .REPEAT_TICKS(4), .CW(24)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .mIzq(mIzq), .mDer(mDer), .mArriba(mArriba), .mAbajo(mAbajo),
    .PosX(PosX), .PosY(PosY), .Moved(Moved)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    repeat (n) begin
      @(posedge Clk);
      #1;
      if (Moved) p++;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    wait_edges(2);
    Reset = 1'b0;
    wait_edges(2);
  endtask

  task automatic keys(input logic l, input logic r, input logic u, input logic d);
    mIzq = l; mDer = r; mArriba = u; mAbajo = d;
  endtask

  initial begin
    int p2;
    keys(0, 0, 0, 0);
    Reset = 1'b1;
    #1;
    check("rst_posx", int'(PosX), 320);
    check("rst_posy", int'(PosY), 240);
    check("rst_moved", int'(Moved), 0);
    wait_edges(2);
    Reset = 1'b0;

    // 1: idle for 100 cycles
    count_pulses(100, pulses);
    check("idle_pulses", pulses, 0);
    check("idle_posx", int'(PosX), 320);
    check("idle_posy", int'(PosY), 240);

    // 1b: reset mid-wait, held key gets a fresh first step
    keys(0, 1, 0, 0);
    wait_edges(4);
    check("mw_first_step", int'(PosX), 328);
    wait_edges(2);
    Reset = 1'b1;
    #1;
    check("mw_rst_posx", int'(PosX), 320);
    check("mw_rst_posy", int'(PosY), 240);
    check("mw_rst_moved", int'(Moved), 0);
    wait_edges(2);
    Reset = 1'b0;
    wait_edges(3);
    check("mw_fresh_wait", int'(PosX), 320);
    wait_edges(1);
    check("mw_fresh_step", int'(PosX), 328);
    check("mw_fresh_moved", int'(Moved), 1);
    keys(0, 0, 0, 0);
    wait_edges(10);

    // 2: right held, first step at k+3, delay 11, repeat 5
    do_reset();
    keys(0, 1, 0, 0);
    wait_edges(3);
    check("r_k2_posx", int'(PosX), 320);
    check("r_k2_moved", int'(Moved), 0);
    wait_edges(1);
    check("r_k3_posx", int'(PosX), 328);
    check("r_k3_moved", int'(Moved), 1);
    wait_edges(1);
    check("r_k4_moved", int'(Moved), 0);
    wait_edges(9);
    check("r_k13_posx", int'(PosX), 328);
    wait_edges(1);
    check("r_k14_posx", int'(PosX), 336);
    check("r_k14_moved", int'(Moved), 1);
    wait_edges(4);
    check("r_k18_posx", int'(PosX), 336);
    wait_edges(1);
    check("r_k19_posx", int'(PosX), 344);
    for (int i = 0; i < 4; i++) begin
      wait_edges(5);
      check($sformatf("r_rep%0d_posx", i), int'(PosX), 352 + 8 * i);
      check($sformatf("r_rep%0d_moved", i), int'(Moved), 1);
    end
    keys(0, 0, 0, 0);
    count_pulses(20, pulses);
    check("r_release_pulses", pulses, 0);
    check("r_release_posx", int'(PosX), 376);

    // 3: left+up diagonal tap for 3 cycles
    do_reset();
    keys(1, 0, 1, 0);
    count_pulses(3, pulses);
    check("diag_early_pulses", pulses, 0);
    keys(0, 0, 0, 0);
    count_pulses(20, pulses);
    check("diag_pulses", pulses, 1);
    check("diag_posx", int'(PosX), 312);
    check("diag_posy", int'(PosY), 232);

    // 4: opposing keys cancel
    do_reset();
    keys(1, 1, 0, 0);
    count_pulses(30, pulses);
    check("cancel_pulses", pulses, 0);
    check("cancel_posx", int'(PosX), 320);
    keys(0, 0, 0, 0);
    wait_edges(5);

    // 5: right edge 632 -> 639 partial clamp, then absorbed repeats
    do_reset();
    keys(0, 1, 0, 0);
    count_pulses(230, pulses);
    keys(0, 0, 0, 0);
    count_pulses(20, p2);
    check("redge_pulses", pulses + p2, 40);
    check("redge_posx", int'(PosX), 639);
    keys(0, 1, 0, 0);
    count_pulses(30, pulses);
    keys(0, 0, 0, 0);
    count_pulses(20, p2);
    check("redge_absorbed", pulses + p2, 0);
    check("redge_hold_posx", int'(PosX), 639);
    // left edge: 639 steps down to 7, then 7 -> 0
    keys(1, 0, 0, 0);
    count_pulses(440, pulses);
    keys(0, 0, 0, 0);
    count_pulses(20, p2);
    check("ledge_pulses", pulses + p2, 80);
    check("ledge_posx", int'(PosX), 0);
    check("ledge_posy", int'(PosY), 240);
    keys(1, 0, 0, 0);
    count_pulses(30, pulses);
    keys(0, 0, 0, 0);
    count_pulses(20, p2);
    check("ledge_absorbed", pulses + p2, 0);
    check("ledge_hold_posx", int'(PosX), 0);

    // 5b: bottom edge 472 -> 479, then top edge 7 -> 0
    do_reset();
    keys(0, 0, 0, 1);
    count_pulses(180, pulses);
    keys(0, 0, 0, 0);
    count_pulses(20, p2);
    check("bedge_pulses", pulses + p2, 30);
    check("bedge_posy", int'(PosY), 479);
    check("bedge_posx", int'(PosX), 320);
    keys(0, 0, 1, 0);
    count_pulses(330, pulses);
    keys(0, 0, 0, 0);
    count_pulses(20, p2);
    check("tedge_pulses", pulses + p2, 60);
    check("tedge_posy", int'(PosY), 0);

    // 6: one-cycle release during WAIT_FIRST restarts from IDLE
    do_reset();
    keys(0, 0, 0, 1);
    wait_edges(4);
    check("gap_k3_posy", int'(PosY), 248);
    check("gap_k3_moved", int'(Moved), 1);
    wait_edges(2);
    keys(0, 0, 0, 0);
    wait_edges(1);
    keys(0, 0, 0, 1);
    wait_edges(3);
    check("gap_k9_posy", int'(PosY), 248);
    wait_edges(1);
    check("gap_k10_posy", int'(PosY), 256);
    check("gap_k10_moved", int'(Moved), 1);
    count_pulses(10, pulses);
    check("gap_delay_pulses", pulses, 0);
    check("gap_k20_posy", int'(PosY), 256);
    wait_edges(1);
    check("gap_k21_posy", int'(PosY), 264);
    check("gap_k21_moved", int'(Moved), 1);
    keys(0, 0, 0, 0);
    wait_edges(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
